// File: rtl/axil2native_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to native bridge: FSM state
// encodings, AXI response codes and a timeout counter width helper.
package axil2native_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A disabled timeout still needs a legal one-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/axil2native_bridge_arb.sv
// Two-way write/read arbiter. Mode 0 always favours the write; mode 1
// alternates, remembering which side won last (write wins first after reset).
module axil2native_arb #(
  parameter int ARB_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic update,
  output logic grant_wr,
  output logic grant_rd
);

  logic prio_wr_q, prio_wr_d;

  // Grant decision and next round-robin pointer
  always_comb begin
    grant_wr  = req_wr && (!req_rd || (ARB_MODE == 0) || prio_wr_q);
    grant_rd  = req_rd && !grant_wr;
    prio_wr_d = prio_wr_q;
    if (update && grant_rd) begin
      prio_wr_d = 1'b1;
    end else if (update && grant_wr) begin
      prio_wr_d = 1'b0;
    end
  end

  // Pointer register, write-first out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_wr_q <= 1'b1;
    end else begin
      prio_wr_q <= prio_wr_d;
    end
  end

endmodule

// File: rtl/axil2native_bridge.sv
// AXI4-Lite slave to single-outstanding native request/strobe bridge.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no native request; arbitrate pending write/read
// ST_WR_REQ  | native write presented, waiting for native_ready/timeout
// ST_RD_REQ  | native read presented, waiting for native_ready/timeout
// ST_WR_RESP | bvalid held until bready
// ST_RD_RESP | rvalid/rdata held until rready
module axil2native_bridge
  import axil2native_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  native_valid,
  input  logic                  native_ready,
  output logic [ADDR_WIDTH-1:0] native_addr,
  output logic [DATA_WIDTH-1:0] native_wdata,
  output logic [STRB_WIDTH-1:0] native_wstrb,
  input  logic [DATA_WIDTH-1:0] native_rdata
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  native_valid_q, native_valid_d;
  logic [ADDR_WIDTH-1:0] native_addr_q, native_addr_d;
  logic [DATA_WIDTH-1:0] native_wdata_q, native_wdata_d;
  logic [STRB_WIDTH-1:0] native_wstrb_q, native_wstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic in_idle, grant_wr, grant_rd, native_fire, tmo_expire;
  logic unused_prot;

  // Protection bits carry no meaning for the native side.
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  assign s_axil_awready = !aw_full_q && !rst;
  assign s_axil_wready  = !w_full_q && !rst;
  assign s_axil_arready = !ar_full_q && !rst;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign native_valid   = native_valid_q;
  assign native_addr    = native_addr_q;
  assign native_wdata   = native_wdata_q;
  assign native_wstrb   = native_wstrb_q;

  assign in_idle     = (state_q == ST_IDLE);
  assign native_fire = native_valid_q && native_ready;
  assign tmo_expire  = (TIMEOUT_CYCLES > 0) && (tmo_cnt_q == CNT_W'(1));

  axil2native_arb #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_wr   (in_idle && aw_full_q && w_full_q),
    .req_rd   (in_idle && ar_full_q),
    .update   (in_idle),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd)
  );

  // Holding-register capture plus FSM next state and registered outputs
  always_comb begin
    state_d        = state_q;
    aw_full_d      = aw_full_q;
    aw_addr_d      = aw_addr_q;
    w_full_d       = w_full_q;
    w_data_d       = w_data_q;
    w_strb_d       = w_strb_q;
    ar_full_d      = ar_full_q;
    ar_addr_d      = ar_addr_q;
    native_valid_d = native_valid_q;
    native_addr_d  = native_addr_q;
    native_wdata_d = native_wdata_q;
    native_wstrb_d = native_wstrb_q;
    bvalid_d       = bvalid_q;
    bresp_d        = bresp_q;
    rvalid_d       = rvalid_q;
    rresp_d        = rresp_q;
    rdata_d        = rdata_q;
    tmo_cnt_d      = tmo_cnt_q;

    if (s_axil_awvalid && s_axil_awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil_awaddr;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (s_axil_arvalid && s_axil_arready) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axil_araddr;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d        = ST_WR_REQ;
          native_valid_d = 1'b1;
          native_addr_d  = aw_addr_q;
          native_wdata_d = w_data_q;
          native_wstrb_d = w_strb_q;
          tmo_cnt_d      = TMO_LOAD;
        end else if (grant_rd) begin
          state_d        = ST_RD_REQ;
          native_valid_d = 1'b1;
          native_addr_d  = ar_addr_q;
          native_wdata_d = '0;
          native_wstrb_d = '0;
          tmo_cnt_d      = TMO_LOAD;
        end
      end
      ST_WR_REQ: begin
        // A strobe arriving on the expiry cycle still counts as success.
        if (native_fire || tmo_expire) begin
          state_d        = ST_WR_RESP;
          native_valid_d = 1'b0;
          aw_full_d      = 1'b0;
          w_full_d       = 1'b0;
          bvalid_d       = 1'b1;
          bresp_d        = native_fire ? RESP_OKAY : RESP_SLVERR;
        end else if (TIMEOUT_CYCLES > 0) begin
          tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
        end
      end
      ST_RD_REQ: begin
        if (native_fire || tmo_expire) begin
          state_d        = ST_RD_RESP;
          native_valid_d = 1'b0;
          ar_full_d      = 1'b0;
          rvalid_d       = 1'b1;
          rresp_d        = native_fire ? RESP_OKAY : RESP_SLVERR;
          rdata_d        = native_fire ? native_rdata : '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
        end
      end
      ST_WR_RESP: begin
        if (s_axil_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (s_axil_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All bridge state; reset abandons any transaction in flight silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      aw_full_q      <= 1'b0;
      aw_addr_q      <= '0;
      w_full_q       <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
      ar_full_q      <= 1'b0;
      ar_addr_q      <= '0;
      native_valid_q <= 1'b0;
      native_addr_q  <= '0;
      native_wdata_q <= '0;
      native_wstrb_q <= '0;
      bvalid_q       <= 1'b0;
      bresp_q        <= RESP_OKAY;
      rvalid_q       <= 1'b0;
      rresp_q        <= RESP_OKAY;
      rdata_q        <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      aw_full_q      <= aw_full_d;
      aw_addr_q      <= aw_addr_d;
      w_full_q       <= w_full_d;
      w_data_q       <= w_data_d;
      w_strb_q       <= w_strb_d;
      ar_full_q      <= ar_full_d;
      ar_addr_q      <= ar_addr_d;
      native_valid_q <= native_valid_d;
      native_addr_q  <= native_addr_d;
      native_wdata_q <= native_wdata_d;
      native_wstrb_q <= native_wstrb_d;
      bvalid_q       <= bvalid_d;
      bresp_q        <= bresp_d;
      rvalid_q       <= rvalid_d;
      rresp_q        <= rresp_d;
      rdata_q        <= rdata_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

endmodule
